mem_unit_be: RTL and testbench

- Next-generation unified instruction/data memory port for the multicycle CPU.
- Selects the address from PC or ALUOut and accesses one byte-enabled synchronous RAM on a single clock.
- Supports byte, halfword and word loads/stores with sign or zero extension, misalignment detection, configurable wait states and a req/ready handshake.
- Latches the instruction register (IR) and memory data register (MDR); sits between the control FSM and the datapath.

---
 rtl/mem_pkg.sv | 74 +++++++
 rtl/sync_ram_be.sv | 36 +++
 rtl/mem_unit_be.sv | 189 ++++++++++++++++++
 tb/tb_mem_unit_be.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared encodings and helpers for the unified memory port.
//             Covers access sizes, FSM states, byte-lane enables, store-lane
//             replication and load extension.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Byte-lane write enables for a store of the given size at byte offset off.
   // The size code 11 falls through to word.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // A halfword must sit on an even byte address and a word on a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         default: bad = (off != 2'b00);
      endcase
      return bad;
   endfunction

   // Replicate right-aligned store data onto every lane it may land in, so
   // that the byte enables alone decide which lanes are written.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] v;
      case (size)
         SZ_BYTE: v = {4{wd[7:0]}};
         SZ_HALF: v = {2{wd[15:0]}};
         default: v = wd;
      endcase
      return v;
   endfunction

   // Pick the addressed lane out of a raw word and sign- or zero-extend it.
   function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] v;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: v = uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: v = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: v = rdata;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ram_be.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ram_be
//  Purpose  : Single-port synchronous RAM, 32-bit words, four byte-lane write
//             enables and a one-cycle registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ram_be #(
    parameter int    ADDR_W    = 9,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];
    logic [31:0] r_rdata;

    // Byte-lane write plus registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_unit_be.sv
`default_nettype none
// ============================================================================
//  Module   : mem_unit_be
//  Purpose  : Unified instruction/data memory port for the multicycle CPU.
//             Byte/half/word loads and stores with extension, misalignment
//             faults, optional wait states and a req/ready handshake.
//             Holds the instruction register (IR) and memory data register.
//  Revision : 1.0 - initial release
// ============================================================================
import mem_pkg::*;

module mem_unit_be #(
   parameter int    ADDR_W      = 9,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        IorD,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   input  logic [31:0] PC,
   input  logic [31:0] ALUOut,
   input  logic [31:0] wdata,
   output logic [31:0] IR,
   output logic [31:0] MDR,
   output logic        ready,
   output logic        misalign
);

   localparam int         AW        = ADDR_W + 2;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    size_q, size_d;
   logic          lu_q, lu_d;
   logic          irw_q, irw_d;
   logic          wr_q, wr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [31:0]   ir_q, ir_d;
   logic [31:0]   mdr_q, mdr_d;
   logic          ready_q, ready_d;
   logic          mis_q, mis_d;

   logic [31:0]   live_addr;
   logic          use_live;
   logic [AW-1:0] acc_addr;
   logic [1:0]    acc_size;
   logic          acc_wr;
   logic [31:0]   acc_wdata;
   logic          ram_go;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic [31:0]   load_val;
   logic          unused_addr_bits;

   assign live_addr        = IorD ? ALUOut : PC;
   assign unused_addr_bits = &{1'b0, live_addr[31:AW]};

   // The array is strobed on the edge that enters ACCESS. With no wait states
   // that edge is the IDLE sample edge, so the access fields come straight from
   // the inputs; otherwise they come from the copy latched in IDLE.
   assign use_live  = (state_q == ST_IDLE);
   assign acc_addr  = use_live ? live_addr[AW-1:0] : addr_q;
   assign acc_size  = use_live ? size              : size_q;
   assign acc_wr    = use_live ? MemWrite          : wr_q;
   assign acc_wdata = use_live ? wdata             : wdata_q;

   // Reset blocks the strobe so a write still waiting for its edge is dropped.
   assign ram_en    = ram_go & ~rst;
   assign ram_we    = (ram_en && acc_wr) ? byte_en(acc_size, acc_addr[1:0]) : 4'b0000;
   assign ram_wdata = store_lanes(acc_size, acc_wdata);

   sync_ram_be #(
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (acc_addr[AW-1:2]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Next-state, capture and handshake logic for the access sequencer.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      lu_d     = lu_q;
      irw_d    = irw_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      wcnt_d   = wcnt_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      ready_d  = 1'b0;
      mis_d    = 1'b0;
      ram_go   = 1'b0;
      load_val = extend_load(ram_rdata, size_q, addr_q[1:0], lu_q);
      case (state_q)
         ST_IDLE: begin
            if (req && (MemRead || MemWrite)) begin
               addr_d  = live_addr[AW-1:0];
               size_d  = size;
               lu_d    = load_unsigned;
               irw_d   = IRWrite;
               wr_d    = MemWrite;
               wdata_d = wdata;
               if (is_misaligned(size, live_addr[1:0])) begin
                  state_d = ST_RESP;
                  ready_d = 1'b1;
                  mis_d   = 1'b1;
               end else if (WAIT_STATES == 0) begin
                  state_d = ST_ACCESS;
                  ram_go  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  wcnt_d  = 4'd0;
               end
            end
         end
         ST_WAIT: begin
            if (wcnt_q == WAIT_LAST) begin
               state_d = ST_ACCESS;
               ram_go  = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            if (!wr_q) begin
               mdr_d = load_val;
               if (irw_q) ir_d = load_val;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         size_q  <= SZ_BYTE;
         lu_q    <= 1'b0;
         irw_q   <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= 32'h0;
         wcnt_q  <= 4'd0;
         ir_q    <= 32'h0;
         mdr_q   <= 32'h0;
         ready_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         lu_q    <= lu_d;
         irw_q   <= irw_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         wcnt_q  <= wcnt_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         ready_q <= ready_d;
         mis_q   <= mis_d;
      end
   end

   assign IR       = ir_q;
   assign MDR      = mdr_q;
   assign ready    = ready_q;
   assign misalign = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_unit_be.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_unit_be
//  Purpose  : Scoreboard bench for mem_unit_be. dut0 has no wait states,
//             dut1 has three. Stimulus pushes expected responses; a monitor
//             pops and compares on each ready pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_unit_be;

   localparam logic [1:0] B = 2'b00;
   localparam logic [1:0] H = 2'b01;
   localparam logic [1:0] W = 2'b10;

   logic        clk = 1'b0;
   logic        rst0, rst1, req0, req1;
   logic        IorD, MemRead, MemWrite, IRWrite, load_unsigned;
   logic [1:0]  size;
   logic [31:0] PC, ALUOut, wdata;
   logic [31:0] ir0, mdr0, ir1, mdr1;
   logic        rdy0, mis0, rdy1, mis1;

   always #5 clk = ~clk;

   mem_unit_be #(.ADDR_W(9), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
      .clk(clk), .rst(rst0), .req(req0), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .size(size),
      .load_unsigned(load_unsigned), .PC(PC), .ALUOut(ALUOut), .wdata(wdata),
      .IR(ir0), .MDR(mdr0), .ready(rdy0), .misalign(mis0));

   mem_unit_be #(.ADDR_W(9), .WAIT_STATES(3), .INIT_FILE("")) dut1 (
      .clk(clk), .rst(rst1), .req(req1), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .size(size),
      .load_unsigned(load_unsigned), .PC(PC), .ALUOut(ALUOut), .wdata(wdata),
      .IR(ir1), .MDR(mdr1), .ready(rdy1), .misalign(mis1));

   typedef struct packed {
      logic [31:0] mdr;
      logic [31:0] ir;
      logic        mis;
      logic [31:0] t;
      logic [31:0] lat;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] mdr_m[2];
   logic [31:0] ir_m[2];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic r, input logic m,
                      input logic [31:0] mdr, input logic [31:0] ir);
      exp_t e;
      if (r) begin
         if (qsize(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_ready: got ready=1 expected no response pending", d);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("dut%0d mdr", d), mdr, e.mdr);
            chk($sformatf("dut%0d ir", d), ir, e.ir);
            chk($sformatf("dut%0d misalign", d), {31'b0, m}, {31'b0, e.mis});
            chk($sformatf("dut%0d latency", d), 32'(cyc) - e.t, e.lat);
         end
      end else if (m) begin
         chk($sformatf("dut%0d misalign_without_ready", d), {31'b0, m}, 32'h0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst0) mon(0, rdy0, mis0, mdr0, ir0);
      if (!rst1) mon(1, rdy1, mis1, mdr1, ir1);
   end

   task automatic op_start(input int d, input logic wr, input logic iord, input logic [1:0] sz,
                           input logic lu, input logic irw, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] expd,
                           input logic mis, input int lat);
      exp_t e;
      if (!wr && !mis) begin
         mdr_m[d] = expd;
         if (irw) ir_m[d] = expd;
      end
      e.mdr = mdr_m[d];
      e.ir  = ir_m[d];
      e.mis = mis;
      e.t   = 32'(cyc);
      e.lat = 32'(lat);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      IorD          = iord;
      PC            = iord ? 32'h0000_0043 : addr;
      ALUOut        = iord ? addr : 32'h0000_0043;
      MemWrite      = wr;
      MemRead       = ~wr;
      size          = sz;
      load_unsigned = lu;
      IRWrite       = irw;
      wdata         = wd;
      if (d == 0) req0 = 1'b1;
      else        req1 = 1'b1;
      @(posedge clk); #1;
      req0     = 1'b0;
      req1     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
   endtask

   task automatic op_wait(input int d);
      for (int i = 0; i < 40; i++) begin
         if (qsize(d) == 0) break;
         @(posedge clk);
      end
      #1;
      if (qsize(d) != 0) begin
         checks++;
         errors++;
         $display("FAIL dut%0d timeout: got %0d responses outstanding expected 0", d, qsize(d));
         if (d == 0) q0.delete();
         else        q1.delete();
      end
   endtask

   task automatic op(input int d, input logic wr, input logic iord, input logic [1:0] sz,
                     input logic lu, input logic irw, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] expd,
                     input logic mis, input int lat);
      op_start(d, wr, iord, sz, lu, irw, addr, wd, expd, mis, lat);
      op_wait(d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
      IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
      size = W; load_unsigned = 1'b0; PC = 32'h0; ALUOut = 32'h0; wdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         mdr_m[i] = 32'h0;
         ir_m[i]  = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst dut0 IR", ir0, 32'h0);
      chk("rst dut0 MDR", mdr0, 32'h0);
      chk("rst dut0 ready", {31'b0, rdy0}, 32'h0);
      chk("rst dut0 misalign", {31'b0, mis0}, 32'h0);
      chk("rst dut1 IR", ir1, 32'h0);
      chk("rst dut1 MDR", mdr1, 32'h0);
      chk("rst dut1 ready", {31'b0, rdy1}, 32'h0);
      chk("rst dut1 misalign", {31'b0, mis1}, 32'h0);
      rst0 = 1'b0;
      rst1 = 1'b0;

      // ---------------- dut0: no wait states ----------------
      //     d  wr iord sz lu irw addr          wdata         expected      mis lat
      op(0, 1, 1, W, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
      op(0, 0, 1, W, 0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
      op(0, 0, 0, W, 0, 1, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
      op(0, 1, 1, W, 0, 0, 32'h20, 32'h80FF7F01, 32'h0,        0, 2);
      op(0, 0, 1, B, 0, 0, 32'h23, 32'h0,        32'hFFFFFF80, 0, 2);
      op(0, 0, 1, B, 1, 0, 32'h23, 32'h0,        32'h00000080, 0, 2);
      op(0, 0, 1, H, 0, 0, 32'h20, 32'h0,        32'h00007F01, 0, 2);
      op(0, 0, 1, H, 1, 0, 32'h22, 32'h0,        32'h000080FF, 0, 2);
      op(0, 0, 1, H, 0, 0, 32'h22, 32'h0,        32'hFFFF80FF, 0, 2);
      op(0, 0, 1, B, 0, 0, 32'h21, 32'h0,        32'h0000007F, 0, 2);
      op(0, 1, 1, W, 0, 0, 32'h30, 32'h11223344, 32'h0,        0, 2);
      op(0, 1, 1, B, 0, 0, 32'h31, 32'h123456AB, 32'h0,        0, 2);
      op(0, 0, 1, W, 0, 0, 32'h30, 32'h0,        32'h1122AB44, 0, 2);
      op(0, 1, 1, H, 0, 0, 32'h32, 32'h9999CDEF, 32'h0,        0, 2);
      op(0, 0, 1, 2'b11, 0, 0, 32'h30, 32'h0,    32'hCDEFAB44, 0, 2);
      op(0, 1, 1, W, 0, 0, 32'h40, 32'hA5A5A5A5, 32'h0,        0, 2);
      op(0, 0, 1, W, 0, 1, 32'h42, 32'h0,        32'h0,        1, 1);
      op(0, 1, 1, H, 0, 0, 32'h43, 32'h00001234, 32'h0,        1, 1);
      op(0, 1, 1, W, 0, 0, 32'h41, 32'hFFFFFFFF, 32'h0,        1, 1);
      op(0, 0, 1, W, 0, 0, 32'h40, 32'h0,        32'hA5A5A5A5, 0, 2);

      // req with neither read nor write must produce no response
      IorD = 1'b1; ALUOut = 32'h40; size = W; req0 = 1'b1;
      @(posedge clk); #1;
      req0 = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // ---------------- dut1: three wait states ----------------
      op(1, 1, 1, W, 0, 0, 32'h08, 32'h00000013, 32'h0, 0, 5);
      op(1, 1, 1, W, 0, 0, 32'h0C, 32'h00A00093, 32'h0, 0, 5);
      op_start(1, 0, 0, W, 0, 1, 32'h08, 32'h0, 32'h00000013, 0, 5);
      // a store request while busy must be ignored
      IorD = 1'b1; ALUOut = 32'h08; wdata = 32'hBAD0BAD0; size = W;
      MemWrite = 1'b1; req1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      req1 = 1'b0; MemWrite = 1'b0;
      op_wait(1);
      op(1, 0, 0, W, 0, 1, 32'h0C,  32'h0, 32'h00A00093, 0, 5);
      op(1, 0, 0, W, 0, 1, 32'h808, 32'h0, 32'h00000013, 0, 5);

      // reset while a store waits: store is cancelled, no ready pulse
      IorD = 1'b1; ALUOut = 32'h08; wdata = 32'h55555555; size = W;
      MemWrite = 1'b1; req1 = 1'b1;
      @(posedge clk); #1;
      req1 = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      rst1 = 1'b1;
      @(posedge clk); #1;
      rst1 = 1'b0;
      chk("midrst dut1 ready", {31'b0, rdy1}, 32'h0);
      chk("midrst dut1 IR", ir1, 32'h0);
      chk("midrst dut1 MDR", mdr1, 32'h0);
      mdr_m[1] = 32'h0;
      ir_m[1]  = 32'h0;
      repeat (8) @(posedge clk);
      #1;
      op(1, 0, 1, W, 0, 0, 32'h08, 32'h0, 32'h00000013, 0, 5);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
